apb_accum_sched: RTL and testbench

- APB master-side scheduler that shares the single OR-accumulator APB slave (DATA 0x00, CONTROL 0x04, RESULT 0x08) among N_REQ requesters.
- For each granted request it runs the fixed three-transfer sequence: write DATA, write CONTROL=START, read RESULT. It then returns the accumulated value, or an error, to the requester.
- It sits between client logic and the APB master modport of the accumulator subsystem. It is the only APB master on that bus.

---
 rtl/apb_accum_pkg.sv | 32 +++
 rtl/apb_accum_sched_if.sv | 29 ++
 rtl/apb_accum_sched_rr_arbiter.sv | 37 +++
 rtl/apb_accum_sched.sv | 196 +++++++++++++++++++
 tb/tb_apb_accum_sched.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_accum_pkg.sv
`default_nettype none
// apb_accum_pkg -- register map, FSM state and step encodings shared by the scheduler.
// Rev 1.0
package apb_accum_pkg;

  localparam logic [7:0]  ADDR_DATA   = 8'h00;
  localparam logic [7:0]  ADDR_CTRL   = 8'h04;
  localparam logic [7:0]  ADDR_RESULT = 8'h08;
  localparam logic [31:0] CTRL_START  = 32'h1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STEP_DATA = 2'd0,
    STEP_CTRL = 2'd1,
    STEP_RES  = 2'd2
  } step_t;

  function automatic step_t step_next(input step_t s);
    case (s)
      STEP_DATA: return STEP_CTRL;
      default:   return STEP_RES;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_accum_sched_if.sv
`default_nettype none
// apb_accum_sched_if -- APB bundle between the scheduler (master) and the accumulator slave.
// Rev 1.0
interface apb_accum_sched_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface
`default_nettype wire

// File: rtl/apb_accum_sched_rr_arbiter.sv
`default_nettype none
// rr_arbiter -- combinational round-robin pick: first set request at or after the pointer.
// Rev 1.0
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  wire [N_REQ-1:0] i_req,
  input  wire [ID_W-1:0]  i_ptr,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest hit to the pointer wins.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_id    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_accum_sched.sv
`default_nettype none
// apb_accum_sched -- shares the APB OR-accumulator among N_REQ requesters (W DATA, W CTRL, R RESULT).
// Rev 1.0
module apb_accum_sched
  import apb_accum_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 16,
  parameter  int ADDR_W  = 8,
  parameter  int DATA_W  = 32,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  wire                      PCLK,
  input  wire                      PRESETn,
  input  wire [N_REQ-1:0]          req,
  input  wire [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]         done,
  output logic [DATA_W-1:0]        rsp_result,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [ID_W-1:0]          gnt_id,
  apb_accum_sched_if.master        apb
);

  localparam int TMO_W = $clog2(TIMEOUT);

  state_t              r_state;
  state_t              w_state_nxt;
  step_t               r_step;
  logic [DATA_W-1:0]   r_opnd;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   w_opnd;
  logic [TMO_W-1:0]    r_tmo;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_gnt;
  logic [ID_W-1:0]     w_arb_id;
  logic [N_REQ-1:0]    r_done;
  logic                r_busy;
  logic                r_err;
  logic                w_arb_valid;
  logic                w_finish;
  logic                w_fail;
  logic                w_step_adv;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_arb_valid),
    .o_id    (w_arb_id)
  );

  always_comb begin
    w_opnd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_id == ID_W'(i)) begin
        w_opnd = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    w_fail      = 1'b0;
    w_step_adv  = 1'b0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;

    if (r_state == SETUP || r_state == ACCESS) begin
      apb.PSEL = 1'b1;
      case (r_step)
        STEP_DATA: begin
          apb.PADDR  = ADDR_W'(ADDR_DATA);
          apb.PWRITE = 1'b1;
          apb.PWDATA = r_opnd;
        end
        STEP_CTRL: begin
          apb.PADDR  = ADDR_W'(ADDR_CTRL);
          apb.PWRITE = 1'b1;
          apb.PWDATA = DATA_W'(CTRL_START);
        end
        default: begin
          apb.PADDR  = ADDR_W'(ADDR_RESULT);
        end
      endcase
    end

    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        apb.PENABLE = 1'b1;
        if (apb.PREADY) begin
          if (apb.PSLVERR) begin
            w_finish    = 1'b1;
            w_fail      = 1'b1;
            w_state_nxt = RESP;
          end else if (r_step == STEP_RES) begin
            w_finish    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_step_adv  = 1'b1;
            w_state_nxt = SETUP;
          end
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          // This stalled cycle is the TIMEOUT-th one; give up on the transfer.
          w_finish    = 1'b1;
          w_fail      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_step   <= STEP_DATA;
      r_opnd   <= '0;
      r_tmo    <= '0;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_opnd <= w_opnd;
            r_gnt  <= w_arb_id;
            r_step <= STEP_DATA;
            r_busy <= 1'b1;
          end
        end
        SETUP: begin
          r_tmo <= '0;
        end
        ACCESS: begin
          if (w_step_adv) begin
            r_step <= step_next(r_step);
          end
          if (!apb.PREADY && !w_finish) begin
            r_tmo <= r_tmo + 1'b1;
          end
          if (w_finish) begin
            r_done[r_gnt] <= 1'b1;
            r_err         <= w_fail;
            r_result      <= w_fail ? '0 : apb.PRDATA;
          end
        end
        RESP: begin
          r_busy <= 1'b0;
          r_ptr  <= (r_gnt == ID_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign done       = r_done;
  assign rsp_result = r_result;
  assign rsp_err    = r_err;
  assign busy       = r_busy;
  assign gnt_id     = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_apb_accum_sched.sv
`default_nettype none
// tb_apb_accum_sched -- table-driven bench with an OR-accumulator slave model and result scoreboard.
// Rev 1.0
module tb_apb_accum_sched;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;

  logic                    PCLK = 1'b0;
  logic                    PRESETn = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       rsp_result;
  logic                    rsp_err;
  logic                    busy;
  logic [1:0]              gnt_id;

  apb_accum_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  apb_accum_sched #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req        (req),
    .req_data   (req_data),
    .done       (done),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .gnt_id     (gnt_id),
    .apb        (apb)
  );

  always #5 PCLK = ~PCLK;

  // Accumulator slave model with configurable wait states and error injection.
  int          cfg_wait_ctrl = 0;
  bit          cfg_err_data  = 1'b0;
  bit          cfg_stuck_res = 1'b0;
  logic [31:0] s_data;
  logic [31:0] s_acc;
  int          s_wcnt;

  always_comb begin
    apb.PREADY  = 1'b1;
    apb.PSLVERR = 1'b0;
    apb.PRDATA  = (apb.PADDR == 8'h08) ? s_acc : 32'h0;
    if (apb.PSEL && apb.PENABLE) begin
      if (apb.PADDR == 8'h04 && s_wcnt < cfg_wait_ctrl) apb.PREADY = 1'b0;
      if (apb.PADDR == 8'h08 && cfg_stuck_res) apb.PREADY = 1'b0;
      if (apb.PADDR == 8'h00 && cfg_err_data) apb.PSLVERR = 1'b1;
    end
  end

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      s_data <= 32'h0;
      s_acc  <= 32'h0;
      s_wcnt <= 0;
    end else if (apb.PSEL && apb.PENABLE) begin
      if (!apb.PREADY) begin
        s_wcnt <= s_wcnt + 1;
      end else begin
        s_wcnt <= 0;
        if (apb.PWRITE && !apb.PSLVERR) begin
          if (apb.PADDR == 8'h00) s_data <= apb.PWDATA;
          else if (apb.PADDR == 8'h04 && apb.PWDATA[0]) s_acc <= s_acc | s_data;
        end
      end
    end else begin
      s_wcnt <= 0;
    end
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    int          wait_ctrl;
    bit          err_data;
    bit          stuck_res;
    logic [31:0] res;
    bit          err;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    bit          err;
  } exp_t;

  vec_t       vecs[8];
  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;

  logic [N_REQ-1:0] last_done;
  int  seq_cyc, seq_xfers, psel_cnt, cur_len, ctrl_len, res_len, done_lat;
  logic [1:0] seq_gnt;
  bit  prev_setup, prev_access, prev_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] res, input bit err);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.err = err;
    sb_q.push_back(e);
  endtask

  // One clock: sample at the falling edge, run the APB monitor and scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge PCLK);
    last_done = done;
    if (apb.PSEL && !apb.PENABLE) begin
      if (apb.PADDR == 8'h00) begin
        seq_cyc = 0; seq_xfers = 0; psel_cnt = 0;
        ctrl_len = 0; res_len = 0; seq_gnt = gnt_id;
      end else begin
        seq_cyc++;
      end
      seq_xfers++;
      cur_len = 0;
    end else begin
      seq_cyc++;
    end
    if (apb.PSEL) psel_cnt++;
    if (apb.PENABLE) begin
      chk("penable_without_psel", {31'h0, apb.PSEL}, 32'h1);
      if (apb.PSEL) begin
        cur_len++;
        if (apb.PADDR == 8'h04) ctrl_len = cur_len;
        if (apb.PADDR == 8'h08) res_len = cur_len;
        chk("access_without_setup", {31'h0, prev_setup || (prev_access && !prev_ready)}, 32'h1);
      end
    end
    if (done != '0) begin
      done_lat = seq_cyc;
      chk("done_onehot", {31'h0, $onehot(done)}, 32'h1);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {28'h0, done}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("done_id", {28'h0, done}, 32'h1 << e.id);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
    prev_setup  = apb.PSEL && !apb.PENABLE;
    prev_access = apb.PSEL && apb.PENABLE;
    prev_ready  = apb.PREADY;
  endtask

  task automatic wait_done(input logic [N_REQ-1:0] mask, input int budget);
    logic [N_REQ-1:0] pend;
    int n;
    pend = mask;
    n = 0;
    while (pend != '0 && n < budget) begin
      tick();
      n++;
      pend = pend & ~last_done;
      req  = req & ~last_done;
    end
    if (pend != '0) begin
      chk("done_timeout", {28'h0, pend}, 32'h0);
      req = req & ~pend;
    end
  endtask

  task automatic apply_vec(input vec_t v);
    cfg_wait_ctrl = v.wait_ctrl;
    cfg_err_data  = v.err_data;
    cfg_stuck_res = v.stuck_res;
    req_data[v.id*DATA_W +: DATA_W] = v.data;
    push_exp(v.id, v.res, v.err);
    req[v.id] = 1'b1;
    wait_done(N_REQ'(1) << v.id, 200);
    chk("gnt_id", {30'h0, seq_gnt}, v.id);
    chk("xfer_count", seq_xfers, v.err_data ? 1 : 3);
    if (v.wait_ctrl != 0) chk("ctrl_access_len", ctrl_len, v.wait_ctrl + 1);
    if (v.stuck_res) chk("res_access_len", res_len, TIMEOUT);
    if (v.err_data) chk("err_done_latency", done_lat, 2);
    if (v.wait_ctrl == 0 && !v.err_data && !v.stuck_res) begin
      chk("done_latency", done_lat, 6);
      chk("psel_cycles", psel_cnt, 6);
    end
    cfg_wait_ctrl = 0;
    cfg_err_data  = 1'b0;
    cfg_stuck_res = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    //          id  data           wait err  stuck  result         err
    vecs[0] = '{0, 32'h0000000C, 0, 1'b0, 1'b0, 32'h0000000C, 1'b0};
    vecs[1] = '{1, 32'h000000B0, 0, 1'b0, 1'b0, 32'h000000BC, 1'b0};
    vecs[2] = '{2, 32'h00000A00, 0, 1'b0, 1'b0, 32'h00000ABC, 1'b0};
    vecs[3] = '{0, 32'h00000000, 0, 1'b0, 1'b0, 32'h00000ABC, 1'b0};
    vecs[4] = '{2, 32'h04000000, 3, 1'b0, 1'b0, 32'h04321ABC, 1'b0};
    vecs[5] = '{3, 32'h08000000, 0, 1'b1, 1'b0, 32'h00000000, 1'b1};
    vecs[6] = '{0, 32'h10000000, 0, 1'b0, 1'b0, 32'h14321ABC, 1'b0};
    vecs[7] = '{1, 32'h20000000, 0, 1'b0, 1'b1, 32'h00000000, 1'b1};

    last_done = '0; seq_cyc = 0; seq_xfers = 0; psel_cnt = 0; cur_len = 0;
    ctrl_len = 0; res_len = 0; done_lat = 0; seq_gnt = '0;
    prev_setup = 1'b0; prev_access = 1'b0; prev_ready = 1'b0;

    tick();
    tick();
    chk("reset_done", {28'h0, done}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_psel", {30'h0, apb.PSEL, apb.PENABLE}, 32'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_gnt_id", {30'h0, gnt_id}, 32'h0);
    chk("reset_paddr", {24'h0, apb.PADDR}, 32'h0);
    PRESETn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) apply_vec(vecs[i]);

    // Pointer now sits at 1: simultaneous 0/1/3 must be served 1, 3, 0.
    req_data[0*DATA_W +: DATA_W] = 32'h00300000;
    req_data[1*DATA_W +: DATA_W] = 32'h00001000;
    req_data[3*DATA_W +: DATA_W] = 32'h00020000;
    push_exp(1, 32'h00001ABC, 1'b0);
    push_exp(3, 32'h00021ABC, 1'b0);
    push_exp(0, 32'h00321ABC, 1'b0);
    req = 4'b1011;
    wait_done(4'b1011, 400);
    for (int i = 0; i < 4; i++) tick();
    chk("rr_sb_drained", sb_q.size(), 0);

    for (int i = 4; i < 8; i++) apply_vec(vecs[i]);

    // Reset in the middle of a stalled RESULT read.
    cfg_stuck_res = 1'b1;
    req_data[2*DATA_W +: DATA_W] = 32'h0;
    req[2] = 1'b1;
    n = 0;
    while (!(apb.PSEL && apb.PENABLE && apb.PADDR == 8'h08) && n < 100) begin
      tick();
      n++;
    end
    chk("reached_result_access", {31'h0, apb.PSEL && apb.PENABLE}, 32'h1);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_reset_psel", {31'h0, apb.PSEL}, 32'h0);
    chk("mid_reset_penable", {31'h0, apb.PENABLE}, 32'h0);
    chk("mid_reset_busy", {31'h0, busy}, 32'h0);
    chk("mid_reset_done", {28'h0, done}, 32'h0);
    req = '0;
    cfg_stuck_res = 1'b0;
    tick();
    tick();
    PRESETn = 1'b1;
    tick();
    chk("post_reset_busy", {31'h0, busy}, 32'h0);

    // Pointer back at 0: requester 1 must win over requester 2.
    req_data[1*DATA_W +: DATA_W] = 32'h40000000;
    req_data[2*DATA_W +: DATA_W] = 32'h00000005;
    push_exp(1, 32'h40000000, 1'b0);
    push_exp(2, 32'h40000005, 1'b0);
    req = 4'b0110;
    wait_done(4'b0110, 400);
    for (int i = 0; i < 3; i++) tick();
    chk("post_reset_sb_drained", sb_q.size(), 0);
    chk("rsp_result_hold", rsp_result, 32'h40000005);
    chk("rsp_err_hold", {31'h0, rsp_err}, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
